// File: rtl/dmshr_arb_if.sv
// Request/grant bundle between the dcache MSHR entries, the refill arbiter and memory.
// The arbiter takes the slave view; the MSHR and memory side takes the master view.
interface dmshr_arb_if #(
    parameter int NUM_MSHR = 4,
    parameter int PADDR_W  = 48
);
    localparam int ID_W = $clog2(NUM_MSHR);

    logic [NUM_MSHR-1:0]         dmshr2arb_valid;
    logic [NUM_MSHR*PADDR_W-1:0] dmshr2arb_paddr;
    logic [NUM_MSHR-1:0]         arb2dmshr_grant;
    logic                        arb2mem_valid;
    logic [PADDR_W-1:0]          arb2mem_paddr;
    logic [ID_W-1:0]             arb2mem_id;
    logic                        mem2arb_ready;

    modport slave (
        input  dmshr2arb_valid,
        input  dmshr2arb_paddr,
        input  mem2arb_ready,
        output arb2dmshr_grant,
        output arb2mem_valid,
        output arb2mem_paddr,
        output arb2mem_id
    );

    modport master (
        output dmshr2arb_valid,
        output dmshr2arb_paddr,
        output mem2arb_ready,
        input  arb2dmshr_grant,
        input  arb2mem_valid,
        input  arb2mem_paddr,
        input  arb2mem_id
    );
endinterface

// File: rtl/dmshr_arb.sv
// Round-robin arbiter issuing MSHR line-refill reads on a valid/ready memory channel.
// An entry is issued once per assertion of its valid; it must drop valid to be re-issued.
module dmshr_arb #(
    parameter int NUM_MSHR      = 4,
    parameter int PADDR_W       = 48,
    parameter int LINE_OFFSET_W = 6
) (
    input  logic        clock,
    input  logic        reset,
    dmshr_arb_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_MSHR);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t               state_q,  state_d;
    logic                 valid_q,  valid_d;
    logic [PADDR_W-1:0]   paddr_q,  paddr_d;
    logic [ID_W-1:0]      id_q,     id_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_MSHR-1:0]  issued_q, issued_d;

    logic                 hs_s;
    logic [NUM_MSHR-1:0]  grant_s;
    logic [NUM_MSHR-1:0]  eligible_s;
    logic [ID_W-1:0]      next_ptr_s;
    logic [ID_W-1:0]      pick_start_s;
    logic [ID_W:0]        pick_s;
    logic                 pick_found_s;
    logic [ID_W-1:0]      pick_id_s;
    logic [PADDR_W-1:0]   sel_paddr_s;

    // Wrap with an explicit compare so non-power-of-2 entry counts never reach NUM_MSHR.
    function automatic logic [ID_W-1:0] inc_wrap_f(input logic [ID_W-1:0] idx);
        inc_wrap_f = (idx == ID_W'(NUM_MSHR - 1)) ? {ID_W{1'b0}} : idx + 1'b1;
    endfunction

    // Returns {found, index} of the first set bit scanning upward from start with wrap.
    function automatic logic [ID_W:0] pick_f(input logic [NUM_MSHR-1:0] elig,
                                             input logic [ID_W-1:0]     start);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] res;
        logic            found;
        idx   = start;
        res   = {ID_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NUM_MSHR; k++) begin
            if (!found && elig[idx]) begin
                found = 1'b1;
                res   = idx;
            end else begin
                found = found;
            end
            idx = inc_wrap_f(idx);
        end
        pick_f = {found, res};
    endfunction

    // Handshake, grant pulse and round-robin candidate selection.
    always_comb begin
        hs_s       = valid_q & bus.mem2arb_ready;
        next_ptr_s = inc_wrap_f(id_q);
        for (int i = 0; i < NUM_MSHR; i++) begin
            grant_s[i] = hs_s & (id_q == ID_W'(i));
        end
        // The granted entry still reads as not-issued this cycle, so mask it out here.
        eligible_s   = bus.dmshr2arb_valid & ~issued_q & ~grant_s;
        pick_start_s = hs_s ? next_ptr_s : rr_ptr_q;
        pick_s       = pick_f(eligible_s, pick_start_s);
        pick_found_s = pick_s[ID_W];
        pick_id_s    = pick_s[ID_W-1:0];
        sel_paddr_s  = {PADDR_W{1'b0}};
        for (int i = 0; i < NUM_MSHR; i++) begin
            sel_paddr_s = (pick_id_s == ID_W'(i)) ?
                          bus.dmshr2arb_paddr[i*PADDR_W +: PADDR_W] : sel_paddr_s;
        end
    end

    // Next-state logic for the request FSM, output registers and issue tracking.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        paddr_d  = paddr_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        issued_d = bus.dmshr2arb_valid & (issued_q | grant_s);
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_REQ;
                    valid_d = 1'b1;
                    paddr_d = {sel_paddr_s[PADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
                    id_d    = pick_id_s;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (hs_s) begin
                    rr_ptr_d = next_ptr_s;
                    if (pick_found_s) begin
                        paddr_d = {sel_paddr_s[PADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
                        id_d    = pick_id_s;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            paddr_q  <= {PADDR_W{1'b0}};
            id_q     <= {ID_W{1'b0}};
            rr_ptr_q <= {ID_W{1'b0}};
            issued_q <= {NUM_MSHR{1'b0}};
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            paddr_q  <= paddr_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            issued_q <= issued_d;
        end
    end

    assign bus.arb2dmshr_grant = grant_s;
    assign bus.arb2mem_valid   = valid_q;
    assign bus.arb2mem_paddr   = paddr_q;
    assign bus.arb2mem_id      = id_q;
endmodule

// File: tb/tb_dmshr_arb.sv
// Directed bench for dmshr_arb: vector table on a 4-entry instance plus a
// hand-written sequence on a 3-entry instance for the pointer wrap.
module tb_dmshr_arb;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmshr_arb_if #(.NUM_MSHR(4), .PADDR_W(48)) b4 ();
    dmshr_arb_if #(.NUM_MSHR(3), .PADDR_W(48)) b3 ();

    dmshr_arb #(.NUM_MSHR(4), .PADDR_W(48), .LINE_OFFSET_W(6)) dut4 (
        .clock (clk),
        .reset (reset),
        .bus   (b4)
    );

    dmshr_arb #(.NUM_MSHR(3), .PADDR_W(48), .LINE_OFFSET_W(6)) dut3 (
        .clock (clk),
        .reset (reset),
        .bus   (b3)
    );

    localparam logic [47:0] P0  = 48'h0000_AAAA_0007;
    localparam logic [47:0] P1  = 48'h0000_BBBB_0041;
    localparam logic [47:0] P1B = 48'h0000_0000_0080;
    localparam logic [47:0] P2  = 48'h0000_1234_5678;
    localparam logic [47:0] P3  = 48'h0000_CCCC_00FF;
    localparam logic [47:0] M0  = 48'h0000_AAAA_0000;
    localparam logic [47:0] M1B = 48'h0000_0000_0080;
    localparam logic [47:0] M2  = 48'h0000_1234_5640;
    localparam logic [47:0] M3  = 48'h0000_CCCC_00C0;
    localparam logic [47:0] Q0  = 48'h0000_0000_1111;
    localparam logic [47:0] Q1  = 48'h0000_0000_2222;
    localparam logic [47:0] Q2  = 48'h8000_0000_33FF;
    localparam logic [47:0] N0  = 48'h0000_0000_1100;
    localparam logic [47:0] N2  = 48'h8000_0000_33C0;
    localparam logic [47:0] Z   = 48'h0;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic        rdy;
        logic [47:0] p1;
        logic        mv;
        logic [1:0]  id;
        logic [47:0] pa;
        logic [3:0]  gnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic rdy,
                                input logic [47:0] p1, input logic mv, input logic [1:0] id,
                                input logic [47:0] pa, input logic [3:0] gnt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rdy = rdy; v.p1 = p1;
        v.mv  = mv;  v.id  = id;  v.pa  = pa;  v.gnt = gnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step3(input string nm, input logic [2:0] vld, input logic rdy,
                         input logic mv, input logic [1:0] id, input logic [47:0] pa,
                         input logic [2:0] gnt);
        b3.dmshr2arb_valid = vld;
        b3.mem2arb_ready   = rdy;
        #1;
        chk({nm, ".mv"}, 64'(b3.arb2mem_valid), 64'(mv));
        chk({nm, ".gnt"}, 64'(b3.arb2dmshr_grant), 64'(gnt));
        if (mv) begin
            chk({nm, ".id"}, 64'(b3.arb2mem_id), 64'(id));
            chk({nm, ".pa"}, 64'(b3.arb2mem_paddr), 64'(pa));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: single entry stalled 3 cycles, then accepted; no re-issue while held.
        vecs.push_back(mk(1'b0, 4'b0100, 1'b0, P1,  1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b0100, 1'b0, P1,  1'b1, 2'd2, M2,  4'b0000));
        vecs.push_back(mk(1'b0, 4'b0100, 1'b0, P1,  1'b1, 2'd2, M2,  4'b0000));
        vecs.push_back(mk(1'b0, 4'b0100, 1'b0, P1,  1'b1, 2'd2, M2,  4'b0000));
        vecs.push_back(mk(1'b0, 4'b0100, 1'b1, P1,  1'b1, 2'd2, M2,  4'b0100));
        vecs.push_back(mk(1'b0, 4'b0100, 1'b1, P1,  1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b0100, 1'b1, P1,  1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, P1,  1'b0, 2'd0, Z,   4'b0000));
        // Test 2: reset pointer to 0, then all four back-to-back.
        vecs.push_back(mk(1'b1, 4'b0000, 1'b0, P1,  1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1,  1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1,  1'b1, 2'd0, M0,  4'b0001));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1,  1'b1, 2'd1, 48'h0000_BBBB_0040, 4'b0010));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1,  1'b1, 2'd2, M2,  4'b0100));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1,  1'b1, 2'd3, M3,  4'b1000));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1,  1'b0, 2'd0, Z,   4'b0000));
        // Test 3: entry 1 drops for a cycle and comes back with a new address.
        vecs.push_back(mk(1'b0, 4'b1101, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1B, 1'b1, 2'd1, M1B, 4'b0010));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));
        // Test 4: pointer at 2 with entries 0 and 3 pending.
        vecs.push_back(mk(1'b0, 4'b1001, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b1001, 1'b1, P1B, 1'b1, 2'd3, M3,  4'b1000));
        vecs.push_back(mk(1'b0, 4'b1001, 1'b1, P1B, 1'b1, 2'd0, M0,  4'b0001));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));
        // Test 5: reset while stalled on entry 1; afterwards 1 then 3 from index 0.
        vecs.push_back(mk(1'b0, 4'b1010, 1'b0, P1B, 1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b1010, 1'b0, P1B, 1'b1, 2'd1, M1B, 4'b0000));
        vecs.push_back(mk(1'b1, 4'b1010, 1'b0, P1B, 1'b1, 2'd1, M1B, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1010, 1'b0, P1B, 1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b1010, 1'b1, P1B, 1'b1, 2'd1, M1B, 4'b0010));
        vecs.push_back(mk(1'b0, 4'b1010, 1'b1, P1B, 1'b1, 2'd3, M3,  4'b1000));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));
        // Held request survives its valid dropping; granting a dropped entry leaves it re-issuable.
        vecs.push_back(mk(1'b0, 4'b0001, 1'b0, P1B, 1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, P1B, 1'b1, 2'd0, M0,  4'b0000));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, P1B, 1'b1, 2'd0, M0,  4'b0001));
        vecs.push_back(mk(1'b0, 4'b0001, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));
        vecs.push_back(mk(1'b0, 4'b0001, 1'b1, P1B, 1'b1, 2'd0, M0,  4'b0001));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, P1B, 1'b0, 2'd0, Z,   4'b0000));

        b4.dmshr2arb_valid = 4'b0000;
        b4.dmshr2arb_paddr = {P3, P2, P1, P0};
        b4.mem2arb_ready   = 1'b0;
        b3.dmshr2arb_valid = 3'b000;
        b3.dmshr2arb_paddr = {Q2, Q1, Q0};
        b3.mem2arb_ready   = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.mv",   64'(b4.arb2mem_valid),   64'h0);
        chk("rst.id",   64'(b4.arb2mem_id),      64'h0);
        chk("rst.pa",   64'(b4.arb2mem_paddr),   64'h0);
        chk("rst.gnt",  64'(b4.arb2dmshr_grant), 64'h0);
        chk("rst3.mv",  64'(b3.arb2mem_valid),   64'h0);
        chk("rst3.pa",  64'(b3.arb2mem_paddr),   64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset              = vecs[i].rst;
            b4.dmshr2arb_valid = vecs[i].vld;
            b4.mem2arb_ready   = vecs[i].rdy;
            b4.dmshr2arb_paddr = {P3, P2, vecs[i].p1, P0};
            #1;
            chk($sformatf("v%0d.mv", i),  64'(b4.arb2mem_valid),   64'(vecs[i].mv));
            chk($sformatf("v%0d.gnt", i), 64'(b4.arb2dmshr_grant), 64'(vecs[i].gnt));
            if (vecs[i].mv) begin
                chk($sformatf("v%0d.id", i), 64'(b4.arb2mem_id),    64'(vecs[i].id));
                chk($sformatf("v%0d.pa", i), 64'(b4.arb2mem_paddr), 64'(vecs[i].pa));
            end
            @(posedge clk);
            #1;
        end

        // Test 6: three entries, pointer brought to 2, wrap must land on 0 then 1.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step3("s1", 3'b010, 1'b1, 1'b0, 2'd0, Z,  3'b000);
        step3("s2", 3'b010, 1'b1, 1'b1, 2'd1, 48'h0000_0000_2200, 3'b010);
        step3("s3", 3'b000, 1'b1, 1'b0, 2'd0, Z,  3'b000);
        step3("s4", 3'b101, 1'b1, 1'b0, 2'd0, Z,  3'b000);
        step3("s5", 3'b101, 1'b1, 1'b1, 2'd2, N2, 3'b100);
        step3("s6", 3'b101, 1'b1, 1'b1, 2'd0, N0, 3'b001);
        step3("s7", 3'b000, 1'b1, 1'b0, 2'd0, Z,  3'b000);
        step3("s8", 3'b111, 1'b1, 1'b0, 2'd0, Z,  3'b000);
        step3("s9", 3'b111, 1'b1, 1'b1, 2'd1, 48'h0000_0000_2200, 3'b010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
